pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined MIPS control unit. Decodes the IF/ID opcode into WB/M/EX control bundles and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers. Adds load-use hazard detection with bubble insertion, branch flush, and an illegal-opcode flag, none of which a flat combinational decoder provides. Sits beside the datapath pipeline registers, between instruction fetch and hazard-free execution.

## Interface
- OPC_W, 6, opcode field width
- RADDR_W, 5, register-address field width
- HAZARD_EN, 1, 1 enables load-use stall detection; 0 ties `stall` low
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  OPC_W  opcode from IF/ID
- if_id_rs  input  RADDR_W  rs field from IF/ID
- if_id_rt  input  RADDR_W  rt field from IF/ID
- id_ex_rt  input  RADDR_W  rt field held in the datapath ID/EX register
- flush  input  1  branch taken, resolved in MEM
- stall  output  1  combinational; freeze PC and IF/ID this cycle
- illegal_op  output  1  registered; opcode in ID was unrecognised
- id_ex_wb  output  2  {RegWrite, MemtoReg}
- id_ex_m  output  3  {Branch, MemRead, MemWrite}
- id_ex_ex  output  4  {RegDst, ALUOp[1:0], ALUSrc}
- ex_mem_wb  output  2  WB bundle in EX/MEM
- ex_mem_m  output  3  M bundle in EX/MEM
- mem_wb_wb  output  2  WB bundle in MEM/WB

## Operation
- Decode (combinational), as {WB, M, EX}:
  - R-type 000000: 10, 000, 1100
  - lw 100011: 11, 010, 0001
  - sw 101011: 00, 001, 0001
  - beq 000100: 00, 100, 0010
  - addi 001000: 10, 000, 0001
  - Any other opcode: all zero, plus the illegal flag.
- Hazard: `stall` = HAZARD_EN & id_ex_m[1] & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt)) & ~flush.
  - Register 0 is not excluded.
- ID/EX load value on each clock:
  - flush or stall: zeros (bubble), illegal_op = 0.
  - Otherwise: the decoded bundles and the illegal flag.
- EX/MEM load value: zeros on flush, else the ID/EX bundles (WB, M only).
- MEM/WB: always loads the EX/MEM WB bundle. The instruction already in MEM completes.
- Simultaneous flush and load-use match: flush wins and `stall` stays low.
- No enable input; all registers load every cycle.

## Timing
- Reset (rst_n low, asynchronous): all registered outputs are 0, so the pipeline holds NOPs.
- `stall` is undefined-free during reset: it evaluates to 0 because id_ex_m is 0.
- Latency from opcode in ID:
  - id_ex_* valid after 1 clock.
  - ex_mem_* valid after 2 clocks.
  - mem_wb_wb valid after 3 clocks.
- A load-use hazard stalls exactly one cycle: the next cycle ID/EX holds a bubble, MemRead is 0, and `stall` drops.
- Flush is sampled on the rising edge and takes effect the same edge. The bubble is visible the following cycle.
- Reset deasserted mid-stream: the first decoded instruction appears in ID/EX one clock after the first rising edge with rst_n high.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI)
  - bundle widths WB_W=2, M_W=3, EX_W=4
  - bit-index constants (M_MEMREAD=1, etc.)
- Sub-module pipe_ctrl_decode: pure combinational opcode to {wb, m, ex, illegal}. It is reused by any later multicycle variant.
- Top level holds the hazard logic and the three pipeline registers.

## Test plan
- Reset: assert rst_n=0 mid-run with nonzero bundles in flight -> all outputs are 0 immediately, without waiting for a clock edge.
- Decode sweep: apply R-type, lw, sw, beq, addi, then 111111 on consecutive cycles.
  - id_ex_{wb,m,ex} follows the table one cycle later.
  - illegal_op = 1 only for 111111.
  - ex_mem and mem_wb follow at +2 and +3 cycles.
- Load-use: lw with id_ex_rt=5, then R-type with rs=5.
  - stall=1 for one cycle.
  - Next cycle id_ex bundles = 0, then the R-type decode appears.
- HAZARD_EN=0: same stimulus as load-use -> stall stays 0 and no bubble is inserted.
- Flush with hazard: flush=1 while the load-use match holds -> stall=0, and both ID/EX and EX/MEM are 0 next cycle.
- Flush alone: flush=1 with lw in EX/MEM -> mem_wb_wb = 11 next cycle, and ex_mem bundles = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, control-bundle layouts and bit positions.
package mips_pkg;

  localparam int unsigned OPCODE_BITS = 6;
  localparam int unsigned RADDR_BITS  = 5;

  localparam logic [OPCODE_BITS-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_BITS-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_BITS-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_BITS-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_BITS-1:0] OP_ADDI  = 6'b001000;

  localparam int unsigned WB_W = 2;
  localparam int unsigned M_W  = 3;
  localparam int unsigned EX_W = 4;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  localparam int unsigned EX_REGDST    = 3;
  localparam int unsigned EX_ALUOP_MSB = 2;
  localparam int unsigned EX_ALUSRC    = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // Full control word as carried in ID/EX
  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  // Reduced control word as carried in EX/MEM
  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
  } wbm_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decoder producing the WB/M/EX control bundles and an illegal flag.
module pipe_ctrl_decode
  import mips_pkg::*;
#(
  parameter int unsigned OPC_W = OPCODE_BITS
) (
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_c_o,
  output logic             illegal_c_o
);

  always_comb begin
    ctrl_c_o    = '0;
    illegal_c_o = 1'b0;
    case (opcode_i)
      OPC_W'(OP_RTYPE): begin
        ctrl_c_o.wb[WB_REGWRITE]              = 1'b1;
        ctrl_c_o.ex[EX_REGDST]                = 1'b1;
        ctrl_c_o.ex[EX_ALUOP_MSB -: 2]        = ALUOP_RTYPE;
      end
      OPC_W'(OP_LW): begin
        ctrl_c_o.wb[WB_REGWRITE]              = 1'b1;
        ctrl_c_o.wb[WB_MEMTOREG]              = 1'b1;
        ctrl_c_o.m[M_MEMREAD]                 = 1'b1;
        ctrl_c_o.ex[EX_ALUOP_MSB -: 2]        = ALUOP_ADD;
        ctrl_c_o.ex[EX_ALUSRC]                = 1'b1;
      end
      OPC_W'(OP_SW): begin
        ctrl_c_o.m[M_MEMWRITE]                = 1'b1;
        ctrl_c_o.ex[EX_ALUOP_MSB -: 2]        = ALUOP_ADD;
        ctrl_c_o.ex[EX_ALUSRC]                = 1'b1;
      end
      OPC_W'(OP_BEQ): begin
        ctrl_c_o.m[M_BRANCH]                  = 1'b1;
        ctrl_c_o.ex[EX_ALUOP_MSB -: 2]        = ALUOP_SUB;
      end
      OPC_W'(OP_ADDI): begin
        ctrl_c_o.wb[WB_REGWRITE]              = 1'b1;
        ctrl_c_o.ex[EX_ALUOP_MSB -: 2]        = ALUOP_ADD;
        ctrl_c_o.ex[EX_ALUSRC]                = 1'b1;
      end
      default: begin
        illegal_c_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, load-use stall, branch flush and the ID/EX, EX/MEM, MEM/WB
// control registers.
module pipe_ctrl_unit
  import mips_pkg::*;
#(
  parameter int unsigned OPC_W     = OPCODE_BITS,
  parameter int unsigned RADDR_W   = RADDR_BITS,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [RADDR_W-1:0] if_id_rs,
  input  logic [RADDR_W-1:0] if_id_rt,
  input  logic [RADDR_W-1:0] id_ex_rt,
  input  logic               flush,
  output logic               stall,
  output logic               illegal_op,
  output logic [WB_W-1:0]    id_ex_wb,
  output logic [M_W-1:0]     id_ex_m,
  output logic [EX_W-1:0]    id_ex_ex,
  output logic [WB_W-1:0]    ex_mem_wb,
  output logic [M_W-1:0]     ex_mem_m,
  output logic [WB_W-1:0]    mem_wb_wb
);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;

  ctrl_t           id_ex_d,   id_ex_q;
  logic            illegal_d, illegal_q;
  wbm_t            ex_mem_d,  ex_mem_q;
  logic [WB_W-1:0] mem_wb_d,  mem_wb_q;

  logic            rs_hit;
  logic            rt_hit;
  logic            load_use;

  pipe_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .opcode_i    (opcode),
    .ctrl_c_o    (dec_ctrl),
    .illegal_c_o (dec_illegal)
  );

  // Load in EX whose destination feeds the instruction in ID; a taken branch overrides it
  always_comb begin
    rs_hit   = (id_ex_rt == if_id_rs);
    rt_hit   = (id_ex_rt == if_id_rt);
    load_use = id_ex_q.m[M_MEMREAD] & (rs_hit | rt_hit);
    stall    = HAZARD_EN & load_use & ~flush;
  end

  always_comb begin
    id_ex_d   = '0;
    illegal_d = 1'b0;
    ex_mem_d  = '0;
    mem_wb_d  = ex_mem_q.wb;
    if (!(flush || stall)) begin
      id_ex_d   = dec_ctrl;
      illegal_d = dec_illegal;
    end
    if (!flush) begin
      ex_mem_d.wb = id_ex_q.wb;
      ex_mem_d.m  = id_ex_q.m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q   <= '0;
      illegal_q <= 1'b0;
      ex_mem_q  <= '0;
      mem_wb_q  <= '0;
    end else begin
      id_ex_q   <= id_ex_d;
      illegal_q <= illegal_d;
      ex_mem_q  <= ex_mem_d;
      mem_wb_q  <= mem_wb_d;
    end
  end

  assign illegal_op = illegal_q;
  assign id_ex_wb   = id_ex_q.wb;
  assign id_ex_m    = id_ex_q.m;
  assign id_ex_ex   = id_ex_q.ex;
  assign ex_mem_wb  = ex_mem_q.wb;
  assign ex_mem_m   = ex_mem_q.m;
  assign mem_wb_wb  = mem_wb_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (hazard detection on/off) checked every cycle against
// a stage-list model, plus directed literal checks.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [4:0] if_id_rs = '0;
  logic [4:0] if_id_rt = '0;
  logic [4:0] id_ex_rt = '0;
  logic       flush = 1'b0;

  logic       stall_a, ill_a, stall_b, ill_b;
  logic [1:0] idwb_a, emwb_a, mwwb_a, idwb_b, emwb_b, mwwb_b;
  logic [2:0] idm_a, emm_a, idm_b, emm_b;
  logic [3:0] idex_a, idex_b;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, BAD = 6'b111111;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.OPC_W(6), .RADDR_W(5), .HAZARD_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rt(id_ex_rt), .flush(flush), .stall(stall_a), .illegal_op(ill_a),
    .id_ex_wb(idwb_a), .id_ex_m(idm_a), .id_ex_ex(idex_a),
    .ex_mem_wb(emwb_a), .ex_mem_m(emm_a), .mem_wb_wb(mwwb_a));

  pipe_ctrl_unit #(.OPC_W(6), .RADDR_W(5), .HAZARD_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rt(id_ex_rt), .flush(flush), .stall(stall_b), .illegal_op(ill_b),
    .id_ex_wb(idwb_b), .id_ex_m(idm_b), .id_ex_ex(idex_b),
    .ex_mem_wb(emwb_b), .ex_mem_m(emm_b), .mem_wb_wb(mwwb_b));

  // Model: per instance, the control word in each stage as {ill, wb[1:0], m[2:0], ex[3:0]}
  logic [8:0] m_idex [2];
  logic       m_ill [2];
  logic [4:0] m_exmem [2];
  logic [1:0] m_memwb [2];

  function automatic logic [9:0] ref_dec(input logic [5:0] op);
    case (op)
      R:       return {1'b0, 2'b10, 3'b000, 4'b1100};
      LW:      return {1'b0, 2'b11, 3'b010, 4'b0001};
      SW:      return {1'b0, 2'b00, 3'b001, 4'b0001};
      BEQ:     return {1'b0, 2'b00, 3'b100, 4'b0010};
      ADDI:    return {1'b0, 2'b10, 3'b000, 4'b0001};
      default: return {1'b1, 9'b0};
    endcase
  endfunction

  // Instance 0 has hazard detection; MemRead of the word in EX is bit 5
  function automatic logic ref_stall(input int h);
    return (h == 0) && m_idex[h][5] &&
           ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt)) && !flush;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic       s;
    logic [9:0] d;
    for (int h = 0; h < 2; h++) begin
      if (!rst_n) begin
        m_idex[h]  = '0;
        m_ill[h]   = 1'b0;
        m_exmem[h] = '0;
        m_memwb[h] = '0;
      end else begin
        s = ref_stall(h);
        d = ref_dec(opcode);
        m_memwb[h] = m_exmem[h][4:3];
        m_exmem[h] = flush ? 5'b0 : m_idex[h][8:4];
        m_idex[h]  = (flush || s) ? 9'b0 : d[8:0];
        m_ill[h]   = (flush || s) ? 1'b0 : d[9];
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int h, input logic st, input logic il, input logic [1:0] iw,
                     input logic [2:0] im, input logic [3:0] ie, input logic [1:0] ew,
                     input logic [2:0] em, input logic [1:0] mw);
    check($sformatf("h%0d stall", h),      16'(st), 16'(ref_stall(h)));
    check($sformatf("h%0d illegal_op", h), 16'(il), 16'(m_ill[h]));
    check($sformatf("h%0d id_ex_wb", h),   16'(iw), 16'(m_idex[h][8:7]));
    check($sformatf("h%0d id_ex_m", h),    16'(im), 16'(m_idex[h][6:4]));
    check($sformatf("h%0d id_ex_ex", h),   16'(ie), 16'(m_idex[h][3:0]));
    check($sformatf("h%0d ex_mem_wb", h),  16'(ew), 16'(m_exmem[h][4:3]));
    check($sformatf("h%0d ex_mem_m", h),   16'(em), 16'(m_exmem[h][2:0]));
    check($sformatf("h%0d mem_wb_wb", h),  16'(mw), 16'(m_memwb[h]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, stall_a, ill_a, idwb_a, idm_a, idex_a, emwb_a, emm_a, mwwb_a);
      cmp(1, stall_b, ill_b, idwb_b, idm_b, idex_b, emwb_b, emm_b, mwwb_b);
    end
  end

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] idrt, input logic fl);
    opcode   = op;
    if_id_rs = rs;
    if_id_rt = rt;
    id_ex_rt = idrt;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("rst stall",      16'(stall_a), 16'h0);
    check("rst illegal_op", 16'(ill_a),   16'h0);
    check("rst id_ex_wb",   16'(idwb_a),  16'h0);
    check("rst ex_mem_m",   16'(emm_a),   16'h0);
    check("rst mem_wb_wb",  16'(mwwb_a),  16'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Decode sweep, no register overlap
    drive(R, 5'd1, 5'd2, 5'd31, 1'b0);    tick();
    check("R id_ex_wb",    16'(idwb_a), 16'h2);
    check("R id_ex_ex",    16'(idex_a), 16'hc);
    drive(LW, 5'd1, 5'd2, 5'd31, 1'b0);   tick();
    check("lw id_ex_m",    16'(idm_a),  16'h2);
    check("R ex_mem_wb",   16'(emwb_a), 16'h2);
    drive(SW, 5'd1, 5'd2, 5'd31, 1'b0);   tick();
    check("sw id_ex_m",    16'(idm_a),  16'h1);
    check("lw ex_mem_m",   16'(emm_a),  16'h2);
    check("R mem_wb_wb",   16'(mwwb_a), 16'h2);
    drive(BEQ, 5'd1, 5'd2, 5'd31, 1'b0);  tick();
    check("beq id_ex_m",   16'(idm_a),  16'h4);
    check("beq id_ex_ex",  16'(idex_a), 16'h2);
    check("lw mem_wb_wb",  16'(mwwb_a), 16'h3);
    drive(ADDI, 5'd1, 5'd2, 5'd31, 1'b0); tick();
    check("addi id_ex_wb", 16'(idwb_a), 16'h2);
    check("addi id_ex_ex", 16'(idex_a), 16'h1);
    check("addi illegal",  16'(ill_a),  16'h0);
    drive(BAD, 5'd1, 5'd2, 5'd31, 1'b0);  tick();
    check("bad illegal",   16'(ill_a),  16'h1);
    check("bad id_ex_wb",  16'(idwb_a), 16'h0);
    check("bad id_ex_ex",  16'(idex_a), 16'h0);
    drive(R, 5'd1, 5'd2, 5'd31, 1'b0);    tick();
    check("R after bad illegal", 16'(ill_a), 16'h0);

    // Load-use: lw to r5 then R-type reading r5
    drive(LW, 5'd1, 5'd2, 5'd5, 1'b0);    tick();
    drive(R, 5'd5, 5'd7, 5'd5, 1'b0);     #1;
    check("lu stall on",   16'(stall_a), 16'h1);
    check("lu stall nohz", 16'(stall_b), 16'h0);
    tick();
    check("lu bubble m",   16'(idm_a),  16'h0);
    check("lu bubble wb",  16'(idwb_a), 16'h0);
    check("lu bubble ex",  16'(idex_a), 16'h0);
    check("lu stall off",  16'(stall_a), 16'h0);
    check("lu lw ex_mem",  16'(emm_a),  16'h2);
    check("nohz R id_ex",  16'(idex_b), 16'hc);
    tick();
    check("lu R id_ex_ex", 16'(idex_a), 16'hc);
    check("lu R id_ex_wb", 16'(idwb_a), 16'h2);

    // Flush while the load-use match holds
    drive(LW, 5'd1, 5'd2, 5'd5, 1'b0);    tick();
    drive(R, 5'd5, 5'd7, 5'd5, 1'b1);     #1;
    check("fh stall",      16'(stall_a), 16'h0);
    tick();
    check("fh id_ex_m",    16'(idm_a),  16'h0);
    check("fh id_ex_wb",   16'(idwb_a), 16'h0);
    check("fh ex_mem_m",   16'(emm_a),  16'h0);
    check("fh ex_mem_wb",  16'(emwb_a), 16'h0);
    check("fh mem_wb_wb",  16'(mwwb_a), 16'h2);

    // Flush alone with lw in EX/MEM: the lw still retires
    drive(LW, 5'd1, 5'd2, 5'd31, 1'b0);   tick();
    drive(R, 5'd1, 5'd2, 5'd31, 1'b0);    tick();
    drive(R, 5'd1, 5'd2, 5'd31, 1'b1);    tick();
    check("fl mem_wb_wb",  16'(mwwb_a), 16'h3);
    check("fl ex_mem_wb",  16'(emwb_a), 16'h0);
    check("fl ex_mem_m",   16'(emm_a),  16'h0);
    check("fl id_ex_wb",   16'(idwb_a), 16'h0);
    check("fl nohz mem_wb", 16'(mwwb_b), 16'h3);
    drive(R, 5'd1, 5'd2, 5'd31, 1'b0);

    // Asynchronous reset with bundles in flight
    drive(LW, 5'd1, 5'd2, 5'd31, 1'b0);   tick();
    drive(R, 5'd1, 5'd2, 5'd31, 1'b0);    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("ar id_ex_wb",   16'(idwb_a), 16'h0);
    check("ar id_ex_ex",   16'(idex_a), 16'h0);
    check("ar ex_mem_wb",  16'(emwb_a), 16'h0);
    check("ar ex_mem_m",   16'(emm_a),  16'h0);
    check("ar mem_wb_wb",  16'(mwwb_a), 16'h0);
    check("ar stall",      16'(stall_a), 16'h0);
    tick();
    rst_n = 1'b1;
    drive(ADDI, 5'd1, 5'd2, 5'd31, 1'b0); tick();
    check("post-rst id_ex_wb", 16'(idwb_a), 16'h2);
    check("post-rst id_ex_ex", 16'(idex_a), 16'h1);
    drive(R, 5'd1, 5'd2, 5'd31, 1'b0);    tick();
    check("post-rst ex_mem_wb", 16'(emwb_a), 16'h2);

    tick();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
